imm_stream: RTL and testbench

IMM_STREAM -- requirements
Module: imm_stream

---
 rtl/imm_pkg.sv | 17 +
 rtl/imm_mask_ram.sv | 25 ++
 rtl/imm_stream.sv | 187 ++++++++++++++++++
 tb/tb_imm_stream.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared definitions for the image mask stream block: operation encodings
// and the width helper used to size counters, offsets and mask addresses.
package imm_pkg;

  typedef enum logic [1:0] {
    MODE_XOR  = 2'd0,
    MODE_AND  = 2'd1,
    MODE_OR   = 2'd2,
    MODE_REPL = 2'd3
  } imm_mode_e;

  // Bits needed to index n items; never less than one bit.
  function automatic int clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/imm_mask_ram.sv
// Mask word storage: one write port and one registered read port.
// A read and a write to the same address in one cycle returns the old word.
module imm_mask_ram #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 4096,
  parameter int AW     = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write and read share the edge; the read samples the array before the write lands.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/imm_stream.sv
// Raster pixel stream with a rectangular mask window. Stage 1 tracks the
// pixel position and issues the mask read; stage 2 applies the operation.
module imm_stream
  import imm_pkg::*;
#(
  parameter int PIX_W  = 12,
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int MASK_W = 64,
  parameter int MASK_H = 64
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  logic [PIX_W-1:0]                     s_pixel,
  input  logic                                 s_sof,
  output logic                                 m_valid,
  input  logic                                 m_ready,
  output logic [PIX_W-1:0]                     m_pixel,
  output logic                                 m_sof,
  output logic                                 m_eof,
  input  logic [clog2w(IMG_W)-1:0]             cfg_x_off,
  input  logic [clog2w(IMG_H)-1:0]             cfg_y_off,
  input  logic [1:0]                           cfg_mode,
  input  logic                                 cfg_en,
  input  logic                                 mask_we,
  input  logic [clog2w(MASK_W*MASK_H)-1:0]     mask_addr,
  input  logic [PIX_W-1:0]                     mask_wdata
);

  localparam int CW = clog2w(IMG_W);
  localparam int RW = clog2w(IMG_H);
  localparam int AW = clog2w(MASK_W * MASK_H);
  localparam int XW = CW + 1;
  localparam int YW = RW + 1;

  function automatic logic [PIX_W-1:0] apply_mask(input imm_mode_e mode, input logic hit,
                                                  input logic [PIX_W-1:0] pix,
                                                  input logic [PIX_W-1:0] mask);
    logic [PIX_W-1:0] r;
    r = pix;
    if (hit) begin
      case (mode)
        MODE_XOR:  r = pix ^ mask;
        MODE_AND:  r = pix & mask;
        MODE_OR:   r = pix | mask;
        MODE_REPL: r = mask;
      endcase
    end
    return r;
  endfunction

  logic [CW-1:0]    col_q, col_d, cur_col, cfg_x_q, cfg_x_d, cur_x, col_rel;
  logic [RW-1:0]    row_q, row_d, cur_row, cfg_y_q, cfg_y_d, cur_y, row_rel;
  imm_mode_e        cfg_mode_q, cfg_mode_d, cur_mode, mode_p1_q, mode_p1_d;
  logic             cfg_en_q, cfg_en_d, cur_en;
  logic [XW-1:0]    col_ext, x_lo, x_hi;
  logic [YW-1:0]    row_ext, y_lo, y_hi;
  logic             adv, acc, in_win, last, rd_en;
  logic [AW-1:0]    rd_addr;
  logic [PIX_W-1:0] mask_rdata;
  logic             vld_p1_q, vld_p1_d, sof_p1_q, sof_p1_d, eof_p1_q, eof_p1_d, hit_p1_q, hit_p1_d;
  logic [PIX_W-1:0] pix_p1_q, pix_p1_d;
  logic             vld_p2_q, vld_p2_d, sof_p2_q, sof_p2_d, eof_p2_q, eof_p2_d;
  logic [PIX_W-1:0] pix_p2_q, pix_p2_d;

  // Next-state for position counters, frame config and both pipeline stages.
  always_comb begin
    adv      = !vld_p2_q || m_ready;
    acc      = s_valid && adv;
    // Stage 0 -> 1: an s_sof pixel restarts at the origin with fresh config.
    cur_col  = s_sof ? '0 : col_q;
    cur_row  = s_sof ? '0 : row_q;
    cur_x    = s_sof ? cfg_x_off : cfg_x_q;
    cur_y    = s_sof ? cfg_y_off : cfg_y_q;
    cur_mode = s_sof ? imm_mode_e'(cfg_mode) : cfg_mode_q;
    cur_en   = s_sof ? cfg_en : cfg_en_q;
    // One extra bit keeps a window running off the image edge from wrapping.
    col_ext  = {1'b0, cur_col};
    row_ext  = {1'b0, cur_row};
    x_lo     = {1'b0, cur_x};
    y_lo     = {1'b0, cur_y};
    x_hi     = x_lo + XW'(MASK_W - 1);
    y_hi     = y_lo + YW'(MASK_H - 1);
    in_win   = (col_ext >= x_lo) && (col_ext <= x_hi) && (row_ext >= y_lo) && (row_ext <= y_hi);
    col_rel  = cur_col - cur_x;
    row_rel  = cur_row - cur_y;
    rd_addr  = AW'(row_rel) * AW'(MASK_W) + AW'(col_rel);
    rd_en    = acc && cur_en && in_win;
    last     = (cur_col == CW'(IMG_W - 1)) && (cur_row == RW'(IMG_H - 1));

    col_d      = col_q;
    row_d      = row_q;
    cfg_x_d    = cfg_x_q;
    cfg_y_d    = cfg_y_q;
    cfg_mode_d = cfg_mode_q;
    cfg_en_d   = cfg_en_q;
    if (acc) begin
      if (cur_col == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (cur_row == RW'(IMG_H - 1)) ? '0 : cur_row + 1'b1;
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end
      if (s_sof) begin
        cfg_x_d    = cfg_x_off;
        cfg_y_d    = cfg_y_off;
        cfg_mode_d = imm_mode_e'(cfg_mode);
        cfg_en_d   = cfg_en;
      end
    end

    vld_p1_d  = adv ? s_valid : vld_p1_q;
    pix_p1_d  = adv ? s_pixel : pix_p1_q;
    sof_p1_d  = adv ? s_sof : sof_p1_q;
    eof_p1_d  = adv ? last : eof_p1_q;
    hit_p1_d  = adv ? (cur_en && in_win) : hit_p1_q;
    mode_p1_d = adv ? cur_mode : mode_p1_q;

    // Stage 1 -> 2: mask word is valid alongside the stage-1 pixel.
    vld_p2_d = adv ? vld_p1_q : vld_p2_q;
    pix_p2_d = adv ? apply_mask(mode_p1_q, hit_p1_q, pix_p1_q, mask_rdata) : pix_p2_q;
    sof_p2_d = adv ? sof_p1_q : sof_p2_q;
    eof_p2_d = adv ? eof_p1_q : eof_p2_q;
  end

  // Control state and output stage, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q      <= '0;
      row_q      <= '0;
      cfg_x_q    <= '0;
      cfg_y_q    <= '0;
      cfg_mode_q <= MODE_XOR;
      cfg_en_q   <= 1'b0;
      vld_p1_q   <= 1'b0;
      vld_p2_q   <= 1'b0;
      pix_p2_q   <= '0;
      sof_p2_q   <= 1'b0;
      eof_p2_q   <= 1'b0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      cfg_x_q    <= cfg_x_d;
      cfg_y_q    <= cfg_y_d;
      cfg_mode_q <= cfg_mode_d;
      cfg_en_q   <= cfg_en_d;
      vld_p1_q   <= vld_p1_d;
      vld_p2_q   <= vld_p2_d;
      pix_p2_q   <= pix_p2_d;
      sof_p2_q   <= sof_p2_d;
      eof_p2_q   <= eof_p2_d;
    end
  end

  // Stage-1 payload; only meaningful while vld_p1_q is set, so no reset.
  always_ff @(posedge clk) begin
    pix_p1_q  <= pix_p1_d;
    sof_p1_q  <= sof_p1_d;
    eof_p1_q  <= eof_p1_d;
    hit_p1_q  <= hit_p1_d;
    mode_p1_q <= mode_p1_d;
  end

  imm_mask_ram #(
    .DATA_W (PIX_W),
    .DEPTH  (MASK_W * MASK_H),
    .AW     (AW)
  ) u_mask_ram (
    .clk   (clk),
    .we    (mask_we),
    .waddr (mask_addr),
    .wdata (mask_wdata),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (mask_rdata)
  );

  assign s_ready = adv;
  assign m_valid = vld_p2_q;
  assign m_pixel = pix_p2_q;
  assign m_sof   = sof_p2_q;
  assign m_eof   = eof_p2_q;

endmodule

// File: tb/tb_imm_stream.sv
// Randomized bench for imm_stream with a frame-position reference model.
module tb_imm_stream;
  import imm_pkg::*;

  localparam int PIX_W  = 12;
  localparam int IMG_W  = 320;
  localparam int IMG_H  = 10;
  localparam int MASK_W = 64;
  localparam int MASK_H = 8;
  localparam int CW     = clog2w(IMG_W);
  localparam int RW     = clog2w(IMG_H);
  localparam int AW     = clog2w(MASK_W * MASK_H);
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int NMASK  = MASK_W * MASK_H;

  logic             clk, rst_n;
  logic             s_valid, s_ready, s_sof;
  logic [PIX_W-1:0] s_pixel;
  logic             m_valid, m_ready, m_sof, m_eof;
  logic [PIX_W-1:0] m_pixel;
  logic [CW-1:0]    cfg_x_off;
  logic [RW-1:0]    cfg_y_off;
  logic [1:0]       cfg_mode;
  logic             cfg_en;
  logic             mask_we;
  logic [AW-1:0]    mask_addr;
  logic [PIX_W-1:0] mask_wdata;

  imm_stream #(
    .PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .MASK_W(MASK_W), .MASK_H(MASK_H)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_pixel(s_pixel), .s_sof(s_sof),
    .m_valid(m_valid), .m_ready(m_ready), .m_pixel(m_pixel), .m_sof(m_sof), .m_eof(m_eof),
    .cfg_x_off(cfg_x_off), .cfg_y_off(cfg_y_off), .cfg_mode(cfg_mode), .cfg_en(cfg_en),
    .mask_we(mask_we), .mask_addr(mask_addr), .mask_wdata(mask_wdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: frame position is simply the count of pixels since s_sof.
  logic [PIX_W-1:0] mdl_mask [NMASK];
  int               mdl_k, mdl_xo, mdl_yo, mdl_mode;
  bit               mdl_en;
  logic [PIX_W-1:0] exp_pix [$];
  bit               exp_sof [$];
  bit               exp_eof [$];
  logic [PIX_W-1:0] obs_pix [$];
  int               eof_cnt;

  task automatic mdl_reset();
    mdl_k = 0; mdl_xo = 0; mdl_yo = 0; mdl_mode = 0; mdl_en = 0;
    exp_pix.delete(); exp_sof.delete(); exp_eof.delete();
  endtask

  task automatic mdl_accept(input logic [PIX_W-1:0] pix, input bit sof);
    int col, row;
    logic [PIX_W-1:0] o, m;
    if (sof) begin
      mdl_k = 0; mdl_xo = int'(cfg_x_off); mdl_yo = int'(cfg_y_off);
      mdl_mode = int'(cfg_mode); mdl_en = cfg_en;
    end
    col = mdl_k % IMG_W;
    row = mdl_k / IMG_W;
    o = pix;
    if (mdl_en && col >= mdl_xo && col < mdl_xo + MASK_W && row >= mdl_yo && row < mdl_yo + MASK_H) begin
      m = mdl_mask[(row - mdl_yo) * MASK_W + (col - mdl_xo)];
      case (mdl_mode)
        0:       o = pix ^ m;
        1:       o = pix & m;
        2:       o = pix | m;
        default: o = m;
      endcase
    end
    exp_pix.push_back(o);
    exp_sof.push_back(sof);
    exp_eof.push_back(col == IMG_W - 1 && row == IMG_H - 1);
    mdl_k = (mdl_k + 1) % NPIX;
  endtask

  function automatic int mdl_addr_next();
    return (mdl_k / IMG_W - mdl_yo) * MASK_W + (mdl_k % IMG_W - mdl_xo);
  endfunction

  int               opt_sof_at, opt_rf_idx, opt_rst_at, opt_cfg_at, opt_pix_fixed;
  logic [1:0]       opt_new_mode;
  logic [PIX_W-1:0] opt_rf_data;
  int               rdy_mode, vld_pct;

  task automatic clr_opts();
    opt_sof_at = -1; opt_rf_idx = -1; opt_rst_at = -1; opt_cfg_at = -1; opt_pix_fixed = -1;
    opt_new_mode = 2'd0; opt_rf_data = '0; rdy_mode = 0; vld_pct = 100;
  endtask

  task automatic load_mask(input int kind);
    for (int a = 0; a < NMASK; a++) begin
      @(negedge clk);
      mask_we    = 1'b1;
      mask_addr  = AW'(a);
      mask_wdata = (kind == 0) ? 12'hFFF : PIX_W'($urandom);
      mdl_mask[a] = mask_wdata;
    end
    @(negedge clk);
    mask_we = 1'b0;
  endtask

  // Drive n pixels, check every output transfer, then drain the pipeline.
  task automatic stream(input int n, input bit first_sof);
    int sent, cyc, budget;
    bit have, sof, force_v;
    logic [PIX_W-1:0] pix;
    sent = 0; cyc = 0; have = 0; sof = 0; pix = '0;
    budget = n * 10 + 200;
    obs_pix.delete();
    eof_cnt = 0;
    while ((sent < n || exp_pix.size() > 0) && cyc < budget) begin
      @(negedge clk);
      mask_we = 1'b0;
      force_v = 1'b0;
      if (opt_rst_at >= 0 && sent == opt_rst_at) begin
        chk("pre_rst_vld", m_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_vld", m_valid, 0);
        chk("rst_async_pix", m_pixel, 0);
        s_valid = 1'b0; s_sof = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mdl_reset();
        return;
      end
      if (sent < n) begin
        if (!have) begin
          pix  = (opt_pix_fixed >= 0) ? PIX_W'(opt_pix_fixed) : PIX_W'($urandom);
          sof  = (sent == 0 && first_sof) || (sent == opt_sof_at);
          have = 1'b1;
        end
        if (sent == opt_cfg_at) cfg_mode = opt_new_mode;
        force_v = (sent == opt_rf_idx);
        s_valid = force_v || ($urandom_range(99) < vld_pct);
        s_pixel = pix;
        s_sof   = sof;
        if (force_v) begin
          mask_we    = 1'b1;
          mask_addr  = AW'(mdl_addr_next());
          mask_wdata = opt_rf_data;
        end
      end else begin
        s_valid = 1'b0;
        s_sof   = 1'b0;
      end
      case (rdy_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (cyc % 2 == 0);
        default: m_ready = ($urandom_range(99) < 75);
      endcase
      #1;
      if (m_valid) begin
        if (exp_pix.size() == 0) begin
          chk("spurious_vld", m_valid, 0);
        end else if (m_ready) begin
          chk("pix", m_pixel, exp_pix[0]);
          chk("sof", m_sof, exp_sof[0]);
          chk("eof", m_eof, exp_eof[0]);
          obs_pix.push_back(m_pixel);
          eof_cnt += int'(m_eof);
          void'(exp_pix.pop_front()); void'(exp_sof.pop_front()); void'(exp_eof.pop_front());
        end else begin
          chk("hold_pix", m_pixel, exp_pix[0]);
        end
      end
      if (s_valid && s_ready) begin
        mdl_accept(pix, sof);
        if (force_v) mdl_mask[mask_addr] = opt_rf_data;
        sent++;
        have = 1'b0;
      end
      cyc++;
    end
    s_valid = 1'b0; s_sof = 1'b0; mask_we = 1'b0;
    if (cyc >= budget) begin
      chk("stream_timeout", 1, 0);
      mdl_reset();
    end
  endtask

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_sof = 1'b0; s_pixel = '0; m_ready = 1'b1;
    cfg_x_off = '0; cfg_y_off = '0; cfg_mode = 2'd0; cfg_en = 1'b0;
    mask_we = 1'b0; mask_addr = '0; mask_wdata = '0;
    clr_opts();
    mdl_reset();
    repeat (3) @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_pixel", m_pixel, 0);
    chk("rst_m_sof", m_sof, 0);
    chk("rst_m_eof", m_eof, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_s_ready", s_ready, 1);

    load_mask(0);

    // After reset the latched config is pass-through even if cfg_en is raised.
    cfg_en = 1'b1; cfg_x_off = '0; cfg_y_off = '0; cfg_mode = 2'd0;
    stream(50, 1'b0);

    // Two-cycle latency with the sink always ready.
    @(negedge clk);
    m_ready = 1'b1; cfg_en = 1'b0; s_valid = 1'b1; s_sof = 1'b1; s_pixel = 12'h3C7;
    @(posedge clk);
    #1;
    s_valid = 1'b0; s_sof = 1'b0;
    chk("lat_cyc1_vld", m_valid, 0);
    @(posedge clk);
    #1;
    chk("lat_cyc2_vld", m_valid, 1);
    chk("lat_pix", m_pixel, 12'h3C7);
    chk("lat_sof", m_sof, 1);
    repeat (3) @(negedge clk);

    // XOR window at (10,5) with an all-ones mask.
    clr_opts();
    cfg_en = 1'b1; cfg_x_off = CW'(10); cfg_y_off = RW'(5); cfg_mode = 2'd0;
    opt_pix_fixed = 12'h0A5;
    stream(NPIX, 1'b1);
    chk("xor_10_5", obs_pix[5 * IMG_W + 10], 12'hF5A);
    chk("xor_9_5", obs_pix[5 * IMG_W + 9], 12'h0A5);
    chk("xor_10_4", obs_pix[4 * IMG_W + 10], 12'h0A5);
    chk("xor_eof_count", eof_cnt, 1);

    // Window past the right edge is clipped, not wrapped into the next row.
    clr_opts();
    cfg_x_off = CW'(300); cfg_y_off = '0;
    opt_pix_fixed = 0; rdy_mode = 2; vld_pct = 80;
    stream(NPIX, 1'b1);
    chk("clip_c300", obs_pix[300], 12'hFFF);
    chk("clip_c319", obs_pix[319], 12'hFFF);
    chk("clip_c299", obs_pix[299], 12'h000);
    chk("clip_next_c0", obs_pix[IMG_W], 12'h000);
    chk("clip_r1_c300", obs_pix[IMG_W + 300], 12'hFFF);

    load_mask(1);

    // Alternating backpressure over a full frame in AND mode.
    clr_opts();
    rdy_mode = 1;
    cfg_mode = 2'd1;
    cfg_x_off = CW'($urandom_range(IMG_W - 1));
    cfg_y_off = RW'($urandom_range(IMG_H - 1));
    stream(NPIX, 1'b1);
    chk("toggle_count", obs_pix.size(), NPIX);
    chk("toggle_eof_count", eof_cnt, 1);

    // Mode change mid-frame takes effect only from the next frame.
    clr_opts();
    rdy_mode = 2; vld_pct = 70;
    cfg_mode = 2'd0; cfg_x_off = CW'(40); cfg_y_off = RW'(2);
    opt_cfg_at = NPIX / 2; opt_new_mode = 2'd3;
    stream(NPIX, 1'b1);
    clr_opts();
    rdy_mode = 2; vld_pct = 70;
    stream(NPIX, 1'b1);

    // OR mode on a partial frame with random handshakes.
    clr_opts();
    rdy_mode = 2; vld_pct = 60;
    cfg_mode = 2'd2; cfg_x_off = CW'(200); cfg_y_off = RW'(1);
    stream(3 * IMG_W, 1'b1);

    // Mask write to the address being read returns the old word; next frame sees the new one.
    clr_opts();
    cfg_mode = 2'd0; cfg_x_off = CW'(10); cfg_y_off = RW'(3);
    opt_rf_idx = 6 * IMG_W + 20;
    opt_rf_data = ~mdl_mask[(6 - 3) * MASK_W + (20 - 10)];
    stream(NPIX, 1'b1);
    clr_opts();
    stream(NPIX, 1'b1);

    // s_sof in the middle of row 7 restarts the frame at the origin.
    clr_opts();
    rdy_mode = 2; vld_pct = 85;
    cfg_x_off = '0; cfg_y_off = '0; cfg_mode = 2'd0;
    opt_sof_at = 7 * IMG_W + 100;
    stream(7 * IMG_W + 100 + 3 * IMG_W, 1'b1);

    // Masking disabled: pure pass-through.
    clr_opts();
    rdy_mode = 2; vld_pct = 70;
    cfg_en = 1'b0;
    stream(2 * IMG_W, 1'b1);

    // Asynchronous reset mid-frame, then a clean frame.
    clr_opts();
    cfg_en = 1'b1; cfg_mode = 2'd3; cfg_x_off = CW'(5); cfg_y_off = '0;
    opt_rst_at = 4 * IMG_W + 7;
    stream(NPIX, 1'b1);
    chk("post_rst_s_ready", s_ready, 1);
    clr_opts();
    rdy_mode = 2; vld_pct = 80;
    stream(2 * IMG_W, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
